lamp_switch_ctrl: RTL and testbench
===================================

// Module: lamp_switch_ctrl
// PURPOSE
//   Input stage directly upstream of the car lamp controller (water_lamp).
//   Synchronises and debounces the raw dashboard switches.
//   Arbitrates the left/right turn requests into a turn-mode state machine.
//   Drives the clean, registered rstL/rstR/rstBrake/rstDoor enables that water_lamp consumes.
// PARAMETERS
//   DEB_CYCLES  16  consecutive cycles a synchronised input must differ from its accepted value before the new value is accepted; legal range >=2
//   CNT_W       5   debounce counter width; must satisfy 2**CNT_W > DEB_CYCLES-1
// PORTS
//   clk       in   1  system clock, rising edge
//   rstN      in   1  asynchronous, active-low reset
//   swL       in   1  raw left-turn switch, asynchronous to clk
//   swR       in   1  raw right-turn switch, asynchronous to clk
//   swBrake   in   1  raw brake switch, asynchronous to clk
//   swDoor    in   1  raw door switch, asynchronous to clk
//   rstL      out  1  left lamp enable to water_lamp
//   rstR      out  1  right lamp enable to water_lamp
//   rstBrake  out  1  brake enable to water_lamp
//   rstDoor   out  1  door enable to water_lamp
//   mode      out  2  current turn state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD
//   chg       out  1  one-cycle pulse on every change of mode
// BEHAVIOUR
// - Reset: rstN=0 asynchronously clears all synchroniser flops, debounced values, counters and state.
//   - All outputs are 0 and mode=00 while reset is asserted.
//   - Reset asserted mid-operation overrides everything immediately.
//   - After release, inputs that are already high re-debounce from 0.
// - Synchroniser: two flops per switch. Only the second-stage value (sN) is used downstream.
// - Debounce, one per switch, with accepted value db and counter cnt:
//   - If sN==db, cnt<=0.
//   - Otherwise cnt<=cnt+1.
//   - When cnt==DEB_CYCLES-1 while sN!=db: db<=sN and cnt<=0 on that edge.
//   - Any return of sN to db before acceptance clears cnt. A shorter glitch is fully rejected.
// - Brake/door: rstBrake<=dbBrake and rstDoor<=dbDoor, both registered. They are independent of the turn FSM.
// - Turn FSM (registered state; mode=state):
//   - Request decode: L=dbL&~dbR, R=dbR&~dbL, H=dbL&dbR, none=~dbL&~dbR.
//   - IDLE: H->HAZARD, L->LEFT, R->RIGHT, none->IDLE.
//   - LEFT: L stays. none->IDLE. H->HAZARD immediately. R->IDLE (forced gap).
//   - RIGHT: mirror of LEFT.
//   - HAZARD: H stays. Any other request->IDLE (forced gap).
//   - Forced gap: every move between two non-IDLE states except entry into HAZARD passes through IDLE for exactly one cycle, so water_lamp restarts its sequence. The next state is then taken from the requests present in that IDLE cycle.
// - Output decode from the state register, no extra stage:
//   - rstL=(state==LEFT)|(state==HAZARD).
//   - rstR=(state==RIGHT)|(state==HAZARD).
//   - chg=1 for the one cycle after any edge at which state changed; otherwise 0.
// - Latency: a raw switch change held stable reaches rstL/rstR/rstBrake/rstDoor on the (DEB_CYCLES+3)th rising edge after the first edge that samples it: 2 sync, DEB_CYCLES debounce, 1 state/output register.
// - Simultaneous debounced changes of dbL and dbR on the same edge are evaluated as one combined request; there is no ordering between them.
// - Counter saturation cannot occur: cnt is cleared on acceptance.
// TESTING (bench uses DEB_CYCLES=4)
// 1. Reset: hold rstN=0 with all sw=1 -> all outputs 0 and mode=00. Release -> rstL=rstR=rstBrake=rstDoor=1 and mode=11 after 7 edges.
// 2. swL 0->1, held -> rstL=1 and mode=01 exactly 7 edges after the first sampling edge; chg=1 for one cycle; rstR stays 0.
// 3. Glitch: swL high for 3 cycles, then low -> rstL, mode and chg never change; this also holds for a 1-cycle glitch.
// 4. In LEFT, swR 0->1 with swL held -> mode goes 01->11 directly with no IDLE cycle, and rstL stays 1 throughout.
// 5. In LEFT, swL 1->0 and swR 0->1 on the same cycle -> mode 01->00 for exactly 1 cycle, then 10; chg pulses twice.
// 6. In HAZARD with swBrake=1, assert rstN mid-cycle -> all outputs 0 immediately. Release with switches held -> outputs return after 7 edges.

Source files
------------

// File: rtl/lamp_switch_ctrl.sv
// Dashboard switch input stage for water_lamp: two-flop synchronisers,
// per-switch debounce, left/right/hazard turn-mode FSM and registered lamp enables.
module lamp_switch_ctrl #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       swL,
  input  logic       swR,
  input  logic       swBrake,
  input  logic       swDoor,
  output logic       rstL,
  output logic       rstR,
  output logic       rstBrake,
  output logic       rstDoor,
  output logic [1:0] mode,
  output logic       chg
);

  localparam int unsigned NSW   = 4;
  localparam int unsigned IDX_L = 0;
  localparam int unsigned IDX_R = 1;
  localparam int unsigned IDX_B = 2;
  localparam int unsigned IDX_D = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LEFT   = 2'b01,
    ST_RIGHT  = 2'b10,
    ST_HAZARD = 2'b11
  } state_t;

  logic [NSW-1:0]   raw;
  logic [NSW-1:0]   sync1;
  logic [NSW-1:0]   sync2;
  logic [NSW-1:0]   db;
  logic [CNT_W-1:0] cnt [NSW];

  logic   req_l;
  logic   req_r;
  logic   req_h;
  state_t state;
  state_t state_nxt;

  assign raw = {swDoor, swBrake, swR, swL};

  // Two-flop synchroniser for every raw switch
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      db <= '0;
      for (int i = 0; i < NSW; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NSW; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign req_l = db[IDX_L] & ~db[IDX_R];
  assign req_r = db[IDX_R] & ~db[IDX_L];
  assign req_h = db[IDX_L] &  db[IDX_R];

  // Turn-mode next state; a change of turn side always passes through IDLE
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (req_h)      state_nxt = ST_HAZARD;
        else if (req_l) state_nxt = ST_LEFT;
        else if (req_r) state_nxt = ST_RIGHT;
        else            state_nxt = ST_IDLE;
      end
      ST_LEFT: begin
        if (req_h)      state_nxt = ST_HAZARD;
        else if (req_l) state_nxt = ST_LEFT;
        else            state_nxt = ST_IDLE;
      end
      ST_RIGHT: begin
        if (req_h)      state_nxt = ST_HAZARD;
        else if (req_r) state_nxt = ST_RIGHT;
        else            state_nxt = ST_IDLE;
      end
      ST_HAZARD: begin
        if (req_h)      state_nxt = ST_HAZARD;
        else            state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered enables, all updated on the same edge
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= ST_IDLE;
      rstL     <= 1'b0;
      rstR     <= 1'b0;
      rstBrake <= 1'b0;
      rstDoor  <= 1'b0;
      chg      <= 1'b0;
    end else begin
      state    <= state_nxt;
      rstL     <= (state_nxt == ST_LEFT)  || (state_nxt == ST_HAZARD);
      rstR     <= (state_nxt == ST_RIGHT) || (state_nxt == ST_HAZARD);
      rstBrake <= db[IDX_B];
      rstDoor  <= db[IDX_D];
      chg      <= (state_nxt != state);
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_lamp_switch_ctrl.sv
// Self-checking bench for lamp_switch_ctrl: per-cycle scoreboard against a
// history-window reference model, plus directed latency/glitch/gap checks.
module tb_lamp_switch_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned CW  = 2;

  typedef struct packed {
    logic       l;
    logic       r;
    logic       b;
    logic       d;
    logic [1:0] mode;
    logic       chg;
  } obs_t;

  logic       clk;
  logic       rstN;
  logic       swL, swR, swBrake, swDoor;
  logic       rstL, rstR, rstBrake, rstDoor, chg;
  logic [1:0] mode;

  int checks;
  int errors;

  logic drv_rstn, drv_l, drv_r, drv_b, drv_d;

  logic [3:0]     m_s1, m_s2, m_db;
  logic [DEB-1:0] m_hist [4];
  logic [1:0]     m_mode;
  obs_t           m_out;

  obs_t exp_q[$];
  obs_t cur_obs;
  int   n_chg, n_idle, n_l_low;
  int   n;

  lamp_switch_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk(clk), .rstN(rstN),
    .swL(swL), .swR(swR), .swBrake(swBrake), .swDoor(swDoor),
    .rstL(rstL), .rstR(rstR), .rstBrake(rstBrake), .rstDoor(rstDoor),
    .mode(mode), .chg(chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Turn mode after one edge given the debounced left/right levels
  function automatic logic [1:0] next_mode(input logic [1:0] cur, input logic l, input logic r);
    logic [1:0] req;
    req = {r, l};
    if (req == 2'b11)      next_mode = 2'b11;
    else if (cur == 2'b00) next_mode = req;
    else if (cur == req)   next_mode = cur;
    else                   next_mode = 2'b00;
  endfunction

  task automatic model_reset();
    m_s1   = '0;
    m_s2   = '0;
    m_db   = '0;
    m_mode = '0;
    m_out  = '0;
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
  endtask

  // Advance the model across one rising edge using the values being driven
  task automatic model_step();
    logic [1:0] nm;
    if (!drv_rstn) begin
      model_reset();
    end else begin
      nm         = next_mode(m_mode, m_db[0], m_db[1]);
      m_out.l    = nm[0];
      m_out.r    = nm[1];
      m_out.b    = m_db[2];
      m_out.d    = m_db[3];
      m_out.mode = nm;
      m_out.chg  = (nm != m_mode);
      m_mode     = nm;
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
        if (m_hist[i] == {DEB{~m_db[i]}}) m_db[i] = ~m_db[i];
      end
      m_s2 = m_s1;
      m_s1 = {drv_d, drv_b, drv_r, drv_l};
    end
  endtask

  // Drive at the falling edge, predict, then compare just after the rising edge
  task automatic tick(input string tag);
    obs_t want;
    @(negedge clk);
    rstN    = drv_rstn;
    swL     = drv_l;
    swR     = drv_r;
    swBrake = drv_b;
    swDoor  = drv_d;
    model_step();
    exp_q.push_back(m_out);
    @(posedge clk);
    #1;
    cur_obs = {rstL, rstR, rstBrake, rstDoor, mode, chg};
    want    = exp_q.pop_front();
    check_eq(tag, 32'(cur_obs), 32'(want));
    n_chg   += int'(cur_obs.chg);
    n_idle  += int'(cur_obs.mode == 2'b00);
    n_l_low += int'(!cur_obs.l);
  endtask

  task automatic ticks(input string tag, input int cnt);
    for (int i = 0; i < cnt; i++) tick(tag);
  endtask

  task automatic run_until_mode(input string tag, input logic [1:0] m, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(tag);
      if (cur_obs.mode == m) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic clear_counts();
    n_chg   = 0;
    n_idle  = 0;
    n_l_low = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    clear_counts();
    rstN = 1'b0;
    swL = 1'b0; swR = 1'b0; swBrake = 1'b0; swDoor = 1'b0;
    model_reset();

    // Reset held with every switch high, then release
    drv_rstn = 1'b0;
    drv_l = 1'b1; drv_r = 1'b1; drv_b = 1'b1; drv_d = 1'b1;
    ticks("rst_hold", 3);
    check_eq("rst_hold_outs", 32'({rstL, rstR, rstBrake, rstDoor, mode, chg}), 32'd0);
    drv_rstn = 1'b1;
    run_until_mode("rst_rel", 2'b11, n);
    check_eq("rst_rel_lat", 32'(n), 32'd7);
    check_eq("rst_rel_outs", 32'({rstL, rstR, rstBrake, rstDoor}), 32'hF);

    drv_l = 1'b0; drv_r = 1'b0; drv_b = 1'b0; drv_d = 1'b0;
    ticks("settle", 8);

    // Left switch on, held
    drv_l = 1'b1;
    run_until_mode("left_on", 2'b01, n);
    check_eq("left_lat", 32'(n), 32'd7);
    check_eq("left_chg", 32'(chg), 32'd1);
    check_eq("left_rstr", 32'(rstR), 32'd0);
    tick("left_hold");
    check_eq("left_chg_once", 32'(chg), 32'd0);

    drv_l = 1'b0;
    ticks("settle", 8);

    // 3-cycle and 1-cycle glitches are rejected
    clear_counts();
    drv_l = 1'b1; ticks("glitch3", 3);
    drv_l = 1'b0; ticks("glitch3", 8);
    drv_l = 1'b1; ticks("glitch1", 1);
    drv_l = 1'b0; ticks("glitch1", 8);
    check_eq("glitch_chg", 32'(n_chg), 32'd0);
    check_eq("glitch_mode", 32'(mode), 32'd0);

    // A 4-cycle pulse is exactly long enough to be accepted
    clear_counts();
    drv_l = 1'b1; ticks("pulse4", 4);
    drv_l = 1'b0; ticks("pulse4", 12);
    check_eq("pulse4_chg", 32'(n_chg), 32'd2);

    // LEFT -> HAZARD directly when right joins
    drv_l = 1'b1; ticks("to_left", 8);
    clear_counts();
    drv_r = 1'b1;
    run_until_mode("to_haz", 2'b11, n);
    check_eq("haz_lat", 32'(n), 32'd7);
    check_eq("haz_no_idle", 32'(n_idle), 32'd0);
    check_eq("haz_rstl_held", 32'(n_l_low), 32'd0);

    drv_l = 1'b0; drv_r = 1'b0; ticks("settle", 8);
    drv_l = 1'b1; ticks("to_left", 8);

    // LEFT -> RIGHT swap on the same cycle passes one IDLE cycle
    clear_counts();
    drv_l = 1'b0; drv_r = 1'b1;
    ticks("swap", 12);
    check_eq("swap_chg", 32'(n_chg), 32'd2);
    check_eq("swap_idle", 32'(n_idle), 32'd1);
    check_eq("swap_mode", 32'(mode), 32'd2);

    // HAZARD with brake, then asynchronous reset mid-cycle
    drv_l = 1'b1; drv_b = 1'b1;
    ticks("to_haz_brk", 8);
    check_eq("haz_brk_pre", 32'({mode, rstBrake}), 32'h7);
    #2;
    rstN = 1'b0;
    drv_rstn = 1'b0;
    model_reset();
    #1;
    check_eq("rst_async", 32'({rstL, rstR, rstBrake, rstDoor, mode, chg}), 32'd0);
    tick("rst_low");
    drv_rstn = 1'b1;
    run_until_mode("rst_rel2", 2'b11, n);
    check_eq("rst_rel2_lat", 32'(n), 32'd7);
    check_eq("rst_rel2_outs", 32'({rstL, rstR, rstBrake, rstDoor}), 32'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
